clock_divide: RTL and testbench
===============================

CLOCK_DIVIDE -- requirements
Module: clock_divide

Interface
REQ-001 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 Port rst_n, input, 1 bit: reset, asynchronous and active-high. The name is kept per codebase convention; the reset is asserted when rst_n = 1.
REQ-003 Port address, input, 7 bits: register select, sampled every rising edge; there is no separate write strobe.
REQ-004 Port writedata, input, 8 bits: data for the selected register.
REQ-005 Port clk_out, output, 1 bit: divided clock, driven directly from a flop (glitch-free, no combinational path from clk).
REQ-006 Parameter DIV_ADDR, default 7'd1, meaning: the address of the divisor register DIV.

Function
REQ-007 An 8-bit divisor register DIV SHALL be written on a rising edge when address == DIV_ADDR and reset is not asserted.
- Rule: DIV <= writedata.
REQ-008 All other addresses SHALL be ignored, with no state change.
REQ-009 A DIV write SHALL count as a load only when writedata != current DIV.
- Equal-value writes have no effect, so holding address/writedata static must not disturb clk_out.
REQ-010 On a load edge, the block SHALL update DIV, set the 8-bit phase counter cnt to 0 and drive clk_out to 0.
REQ-011 High time H SHALL be (DIV+1)>>1, i.e. ceil(DIV/2).
REQ-012 Low time SHALL be DIV-H.
REQ-013 The clk_out period SHALL be exactly DIV clk cycles when DIV >= 2.
REQ-014 On each non-load edge with DIV >= 2, the block SHALL update as follows:
- clk_out <= (cnt < H).
- cnt <= (cnt == DIV-1) ? 0 : cnt+1.
REQ-015 First rising edge of clk_out SHALL occur on the first edge after a load edge (1-cycle latency).
REQ-016 Even DIV SHALL give 50% duty; odd DIV SHALL have the high phase one cycle longer than the low phase.
REQ-017 With DIV = 0 or DIV = 1, clk_out SHALL be held at 0 and cnt held at 0.
REQ-018 A load while running SHALL abort the current period immediately (clk_out 0 on that edge) and restart with the new DIV; no partial old-period output.
REQ-019 cnt SHALL never exceed DIV-1; arithmetic is 8-bit unsigned with no wrap beyond DIV-1.
REQ-020 Maximum DIV = 255 SHALL give a 255-cycle period: high 128 cycles, low 127 cycles.

Reset
REQ-021 While rst_n = 1, the block SHALL asynchronously force DIV = 0, cnt = 0 and clk_out = 0, independent of clk.
REQ-022 Writes presented during reset SHALL be ignored.
REQ-023 After release, clk_out SHALL stay 0 until a nonzero DIV >= 2 is loaded.
REQ-024 Reset asserted mid-period SHALL drop clk_out to 0 immediately and discard DIV.

Verification
REQ-025 Reset then idle: clk period 100 ns, hold rst_n = 1 for 20 ns, release, address = 0 -> clk_out stays 0 and DIV stays 0.
REQ-026 Divide-by-25: clk period 100 ns; reset until 20 ns; then address = 1, writedata = 25 held for 9000 ns.
- Load edge: 50 ns.
- clk_out: rises 150 ns, falls 1450 ns, rises 2650 ns, falls 3950 ns.
- Period: 2500 ns; high 13 cycles, low 12 cycles.
- Held write must cause no restarts.
REQ-027 Even divisor: write 4 -> clk_out pattern 1,1,0,0 repeating from the edge after the load.
REQ-028 Divisor 0/1 and non-DIV addresses:
- Write 1, then write 0 -> clk_out stays 0.
- Writes to address 2 or 127 -> no change to DIV or clk_out.
REQ-029 Reload mid-period: running with DIV = 25, write 6 while clk_out = 1 -> clk_out = 0 on the load edge, then 3 high / 3 low cycles.
REQ-030 Async reset mid-run: assert rst_n = 1 between clk edges while clk_out = 1 -> clk_out = 0 immediately; output resumes only after DIV is rewritten.

Source files
------------

// File: rtl/clock_divide.sv
// -----------------------------------------------------------------------------
// clock_divide
//
// Programmable clock divider. An 8-bit divisor register DIV is written
// through a simple address/data port that has no write strobe: any edge on
// which address == DIV_ADDR is treated as a write.
//
// With DIV >= 2, clk_out has a period of exactly DIV cycles of clk. It is
// high for H = ceil(DIV/2) cycles and low for DIV - H cycles, so an odd
// divisor gives one extra high cycle. With DIV = 0 or 1, clk_out is held low.
//
// A write is a "load" only when the new data differs from the current DIV.
// Because of this, a static address/data pair pointing at DIV can be left in
// place without restarting the output.
//
// On a load edge the phase counter restarts and clk_out is driven low. The
// first high cycle follows on the next edge.
//
// Handshake: there is no valid/ready pair. The port is sampled on every
// rising edge of clk, and address acts as an implicit always-valid write
// select that is always accepted.
//
// Ports
//   clk        in   1  the only clock; all state changes on its rising edge
//   rst_n      in   1  asynchronous reset, ACTIVE-HIGH despite its name
//   address    in   7  register select, sampled every rising edge
//   writedata  in   8  data for the selected register
//   clk_out    out  1  divided clock, driven straight from a flop
//
// Parameters
//   DIV_ADDR   address of the divisor register (default 7'd1)
// -----------------------------------------------------------------------------
module clock_divide #(
  parameter logic [6:0] DIV_ADDR = 7'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] address,
  input  logic [7:0] writedata,
  output logic       clk_out
);

  // Registered state
  logic [7:0] div_q;
  logic [7:0] cnt_q;
  logic       out_q;

  // Next-state values
  logic [7:0] div_d;
  logic [7:0] cnt_d;
  logic       out_d;

  // Decode and derived quantities
  logic       write_hit;
  logic       load;
  logic       running;
  logic [8:0] div_plus_one;
  logic [7:0] high_time;
  logic [7:0] last_cnt;

  assign write_hit = (address == DIV_ADDR);

  // Rewriting the value already held is not a load, so it cannot
  // restart the phase.
  assign load = write_hit && (writedata != div_q);

  // DIV of 0 or 1 cannot produce a meaningful waveform; the output idles low.
  assign running = (div_q >= 8'd2);

  // The sum is computed 9 bits wide so that DIV = 255 gives H = 128
  // without overflow.
  assign div_plus_one = {1'b0, div_q} + 9'd1;
  assign high_time    = div_plus_one[8:1];

  // Only used while running (DIV >= 2), so this subtraction never underflows.
  assign last_cnt = div_q - 8'd1;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    out_d = out_q;

    if (load) begin
      // A load abandons any period in progress. Nothing from the old
      // divisor leaks past this edge.
      div_d = writedata;
      cnt_d = 8'd0;
      out_d = 1'b0;
    end else if (running) begin
      // The output is registered from the current count. It is therefore
      // high for counts 0..H-1, which are seen one edge later.
      out_d = (cnt_q < high_time);
      cnt_d = (cnt_q == last_cnt) ? 8'd0 : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
      out_d = 1'b0;
    end
  end

  // rst_n is the active-high reset, so the flops clear on its rising edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      div_q <= 8'd0;
      cnt_q <= 8'd0;
      out_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign clk_out = out_q;

endmodule

// File: tb/tb_clock_divide.sv
// -----------------------------------------------------------------------------
// tb_clock_divide
//
// Directed bench for clock_divide. Each step drives the register port on a
// falling clock edge. The clk_out values expected on the following falling
// edges are pushed into exp_q, then popped and compared one per cycle.
//
// Clock period is 100 ns, so rising edges fall at 50, 150, 250, ... ns.
// -----------------------------------------------------------------------------
module tb_clock_divide;

  logic       clk;
  logic       rst_n;
  logic [6:0] address;
  logic [7:0] writedata;
  logic       clk_out;

  logic       exp_q[$];
  int         n_vec;
  int         n_err;

  clock_divide #(.DIV_ADDR(7'd1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .writedata (writedata),
    .clk_out   (clk_out)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Driver tasks
  task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
    address   = a;
    writedata = d;
  endtask

  task automatic push_n(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_pat(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      push_n(1'b1, hi);
      push_n(1'b0, lo);
    end
  endtask

  // Scoreboard: drain exp_q, one comparison per falling edge of clk
  task automatic check_q(input string tag);
    logic exp;
    int   budget;
    budget = exp_q.size() + 1;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_vec++;
      budget--;
      assert (clk_out === exp) else begin
        n_err++;
        $error("FAIL %s: clk_out=%b expected %b at %0t", tag, clk_out, exp, $time);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic exp);
    n_vec++;
    assert (clk_out === exp) else begin
      n_err++;
      $error("FAIL %s: clk_out=%b expected %b at %0t", tag, clk_out, exp, $time);
    end
  endtask

  // Directed sequence
  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    address   = 7'd0;
    writedata = 8'd0;

    #10;
    check_now("rst_hold", 1'b0);
    #10 rst_n = 1'b0;

    // Reset then idle on a non-DIV address
    push_n(1'b0, 4);
    check_q("idle");

    // Divide by 25: load-edge low, then 13 high / 12 low, held write
    write_reg(7'd1, 8'd25);
    push_n(1'b0, 1);
    push_pat(13, 12, 3);
    check_q("div25");
    push_n(1'b1, 5);
    check_q("div25_run");

    // Reload with 6 while clk_out is high
    write_reg(7'd1, 8'd6);
    push_n(1'b0, 1);
    push_pat(3, 3, 3);
    check_q("reload6");

    // Even divisor 4 gives 1,1,0,0
    write_reg(7'd1, 8'd4);
    push_n(1'b0, 1);
    push_pat(2, 2, 3);
    check_q("div4");

    // Other addresses are ignored; the pattern continues undisturbed
    write_reg(7'd2, 8'd9);
    push_pat(2, 2, 2);
    check_q("addr2");
    write_reg(7'd127, 8'd200);
    push_pat(2, 2, 2);
    check_q("addr127");

    // Writing the current value is not a load
    write_reg(7'd1, 8'd4);
    push_pat(2, 2, 2);
    check_q("equal_write");

    // Smallest running divisor
    write_reg(7'd1, 8'd2);
    push_n(1'b0, 1);
    push_pat(1, 1, 4);
    check_q("div2");

    // DIV = 1 and DIV = 0 hold the output low
    write_reg(7'd1, 8'd1);
    push_n(1'b0, 7);
    check_q("div1");
    write_reg(7'd1, 8'd0);
    push_n(1'b0, 6);
    check_q("div0");

    // Maximum divisor: 128 high, 127 low
    write_reg(7'd1, 8'd255);
    push_n(1'b0, 1);
    push_pat(128, 127, 1);
    push_n(1'b1, 3);
    check_q("div255");

    // Async reset while clk_out is high
    write_reg(7'd1, 8'd6);
    push_n(1'b0, 1);
    push_n(1'b1, 2);
    check_q("pre_rst");
    #10 rst_n = 1'b1;
    #1;
    check_now("async_rst", 1'b0);
    push_n(1'b0, 3);
    check_q("in_rst");
    write_reg(7'd0, 8'd6);
    #10 rst_n = 1'b0;
    push_n(1'b0, 6);
    check_q("post_rst_idle");
    write_reg(7'd1, 8'd6);
    push_n(1'b0, 1);
    push_pat(3, 3, 2);
    check_q("resume6");

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
